// File: rtl/pc_seq.sv
// Program-counter sequencer: increment, absolute jump, relative branch and an optional return stack.
// The return stack (CALL/RET, o_Depth, o_Ovf, o_Unf) is built only when PC_SEQ_RET_STACK_EN is defined.
module pc_seq #(
    parameter int PC_W  = 13,
    parameter int BR_W  = 6,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_PC,
    input  logic [2:0]                 i_PCop,
    input  logic [BR_W-1:0]            i_Target,
    output logic [PC_W-1:0]            o_PCcurr,
    output logic [$clog2(DEPTH+1)-1:0] o_Depth,
    output logic                       o_Ovf,
    output logic                       o_Unf
);

    typedef enum logic [2:0] {
        OP_INC  = 3'b000,
        OP_JMP  = 3'b001,
        OP_BRR  = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100
    } pc_op_e;

    pc_op_e op;
    assign op = pc_op_e'(i_PCop);

    logic [PC_W-1:0] pc_q;
    logic [PC_W-1:0] pc_d;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] tgt_zx;
    logic [PC_W-1:0] tgt_sx;

    assign pc_inc = pc_q + PC_W'(1);
    assign tgt_zx = PC_W'(i_Target);
    assign tgt_sx = PC_W'($signed(i_Target));

`ifdef PC_SEQ_RET_STACK_EN
    localparam int DW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DW-1:0] FULL = DW'(DEPTH);

    logic [DW-1:0]   depth_q;
    logic [DW-1:0]   depth_d;
    logic            ovf_q;
    logic            ovf_d;
    logic            unf_q;
    logic            unf_d;
    logic            push_en;
    logic [IW-1:0]   push_idx;
    logic [IW-1:0]   top_idx;
    logic [PC_W-1:0] stk_q [DEPTH];

    // Entry n holds the (n+1)-th pushed return address; depth_q points at the next free slot.
    assign push_idx = IW'(depth_q);
    assign top_idx  = IW'(depth_q - DW'(1));

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        push_en = 1'b0;
        if (i_PC) begin
            case (op)
                OP_INC: pc_d = pc_inc;
                OP_JMP: pc_d = tgt_zx;
                OP_BRR: pc_d = pc_q + tgt_sx;
                OP_CALL: begin
                    if (depth_q == FULL) begin
                        ovf_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        pc_d    = tgt_zx;
                        depth_d = depth_q + DW'(1);
                    end
                end
                OP_RET: begin
                    if (depth_q == '0) begin
                        unf_d = 1'b1;
                    end else begin
                        pc_d    = stk_q[top_idx];
                        depth_d = depth_q - DW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q    <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is never read above depth_q, so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_en) begin
            stk_q[push_idx] <= pc_inc;
        end
    end

    assign o_Depth = depth_q;
    assign o_Ovf   = ovf_q;
    assign o_Unf   = unf_q;
`else
    always_comb begin
        pc_d = pc_q;
        if (i_PC) begin
            case (op)
                OP_INC:  pc_d = pc_inc;
                OP_JMP:  pc_d = tgt_zx;
                OP_BRR:  pc_d = pc_q + tgt_sx;
                OP_CALL: pc_d = tgt_zx;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= '0;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign o_Depth = '0;
    assign o_Ovf   = 1'b0;
    assign o_Unf   = 1'b0;
`endif

    assign o_PCcurr = pc_q;

endmodule

// File: tb/tb_pc_seq.sv
// Bench for pc_seq: queue-based reference model compared every cycle, plus literal spot checks.
// Follows whichever build of the return stack (PC_SEQ_RET_STACK_EN) is compiled.
module tb_pc_seq;

    localparam int PC_W  = 13;
    localparam int BR_W  = 6;
    localparam int DEPTH = 4;
    localparam int DW    = $clog2(DEPTH + 1);
    localparam int PCM   = 1 << PC_W;
    localparam int BRM   = 1 << BR_W;

    localparam logic [2:0] INC  = 3'b000;
    localparam logic [2:0] JMP  = 3'b001;
    localparam logic [2:0] BRR  = 3'b010;
    localparam logic [2:0] CALL = 3'b011;
    localparam logic [2:0] RET  = 3'b100;

    logic            clk = 1'b0;
    logic            reset;
    logic            i_PC;
    logic [2:0]      i_PCop;
    logic [BR_W-1:0] i_Target;
    logic [PC_W-1:0] o_PCcurr;
    logic [DW-1:0]   o_Depth;
    logic            o_Ovf;
    logic            o_Unf;

    int n_checks = 0;
    int n_errors = 0;
    bit chk_on   = 1'b0;

    int m_pc  = 0;
    int m_ovf = 0;
    int m_unf = 0;
    int m_stk[$];

    pc_seq #(.PC_W(PC_W), .BR_W(BR_W), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .i_PC     (i_PC),
        .i_PCop   (i_PCop),
        .i_Target (i_Target),
        .o_PCcurr (o_PCcurr),
        .o_Depth  (o_Depth),
        .o_Ovf    (o_Ovf),
        .o_Unf    (o_Unf)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers and a queue as the return stack.
    always @(posedge clk or negedge reset) begin
        int off;
        if (!reset) begin
            m_pc  = 0;
            m_ovf = 0;
            m_unf = 0;
            m_stk.delete();
        end else begin
            m_ovf = 0;
            m_unf = 0;
            if (i_PC) begin
                case (i_PCop)
                    INC: m_pc = (m_pc + 1) % PCM;
                    JMP: m_pc = int'(i_Target);
                    BRR: begin
                        off = int'(i_Target);
                        if (off >= BRM / 2) off = off - BRM;
                        m_pc = ((m_pc + off) % PCM + PCM) % PCM;
                    end
`ifdef PC_SEQ_RET_STACK_EN
                    CALL: begin
                        if (m_stk.size() == DEPTH) m_ovf = 1;
                        else begin
                            m_stk.push_back((m_pc + 1) % PCM);
                            m_pc = int'(i_Target);
                        end
                    end
                    RET: begin
                        if (m_stk.size() == 0) m_unf = 1;
                        else m_pc = m_stk.pop_back();
                    end
`else
                    CALL: m_pc = int'(i_Target);
`endif
                    default: ;
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            n_checks++;
            if (int'(o_PCcurr) != m_pc || int'(o_Depth) != m_stk.size()
                || int'(o_Ovf) != m_ovf || int'(o_Unf) != m_unf) begin
                n_errors++;
                $display("FAIL model t=%0t: pc=%0h depth=%0d ovf=%0d unf=%0d, want pc=%0h depth=%0d ovf=%0d unf=%0d",
                         $time, o_PCcurr, o_Depth, o_Ovf, o_Unf, m_pc, m_stk.size(), m_ovf, m_unf);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    // Drive one operation from a negedge; returns at the next negedge with its result visible.
    task automatic op(input logic en, input logic [2:0] code, input logic [BR_W-1:0] tgt);
        i_PC     = en;
        i_PCop   = code;
        i_Target = tgt;
        @(negedge clk);
    endtask

    initial begin
        int pc_hold;
        i_PC     = 1'b0;
        i_PCop   = INC;
        i_Target = '0;
        reset    = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        chk_on = 1'b1;
        chk("reset_pc", int'(o_PCcurr), 0);
        chk("reset_depth", int'(o_Depth), 0);
        chk("reset_flags", int'({o_Ovf, o_Unf}), 0);
        reset = 1'b1;

        // Wrap both directions.
        op(1'b1, BRR, 6'b111111);
        chk("brr_wrap_down", int'(o_PCcurr), 'h1FFF);
        op(1'b1, INC, 6'h00);
        chk("inc_wrap", int'(o_PCcurr), 'h0000);
        op(1'b1, JMP, 6'h03);
        op(1'b1, BRR, 6'b111011);
        chk("brr_neg5", int'(o_PCcurr), 'h1FFE);
        op(1'b1, BRR, 6'd5);
        chk("brr_wrap_up", int'(o_PCcurr), 'h0003);

        // Nested call/return.
        op(1'b1, JMP, 6'h10);
        op(1'b1, CALL, 6'h20);
        chk("call1_pc", int'(o_PCcurr), 'h20);
`ifdef PC_SEQ_RET_STACK_EN
        chk("call1_depth", int'(o_Depth), 1);
`endif
        op(1'b1, CALL, 6'h30);
        chk("call2_pc", int'(o_PCcurr), 'h30);
        op(1'b1, RET, 6'h00);
`ifdef PC_SEQ_RET_STACK_EN
        chk("ret1_pc", int'(o_PCcurr), 'h21);
`else
        chk("ret1_hold", int'(o_PCcurr), 'h30);
`endif
        op(1'b1, RET, 6'h00);
`ifdef PC_SEQ_RET_STACK_EN
        chk("ret2_pc", int'(o_PCcurr), 'h11);
`else
        chk("ret2_unf", int'(o_Unf), 0);
`endif
        chk("ret2_depth", int'(o_Depth), 0);

        // Fill stack then overflow; drain then underflow.
        for (int i = 1; i <= DEPTH; i++) op(1'b1, CALL, 6'(i));
        op(1'b1, CALL, 6'h05);
`ifdef PC_SEQ_RET_STACK_EN
        chk("ovf_pc", int'(o_PCcurr), DEPTH);
        chk("ovf_flag", int'(o_Ovf), 1);
        chk("ovf_depth", int'(o_Depth), DEPTH);
`else
        chk("call_as_jmp", int'(o_PCcurr), 'h05);
        chk("call_no_ovf", int'(o_Ovf), 0);
`endif
        op(1'b0, INC, 6'h00);
        chk("ovf_one_cycle", int'(o_Ovf), 0);
        for (int i = 0; i < DEPTH; i++) op(1'b1, RET, 6'h00);
        pc_hold = int'(o_PCcurr);
        op(1'b1, RET, 6'h00);
`ifdef PC_SEQ_RET_STACK_EN
        chk("unf_flag", int'(o_Unf), 1);
`else
        chk("ret_no_unf", int'(o_Unf), 0);
`endif
        chk("unf_pc_hold", int'(o_PCcurr), pc_hold);
        op(1'b1, INC, 6'h00);
        chk("unf_one_cycle", int'(o_Unf), 0);

        // Disabled advance and reserved opcodes.
        pc_hold = int'(o_PCcurr);
        repeat (5) op(1'b0, JMP, 6'h3F);
        chk("en_low_hold", int'(o_PCcurr), pc_hold);
        op(1'b1, 3'b101, 6'h11);
        op(1'b1, 3'b110, 6'h22);
        op(1'b1, 3'b111, 6'h33);
        chk("reserved_hold", int'(o_PCcurr), pc_hold);
        chk("reserved_flags", int'({o_Ovf, o_Unf}), 0);

        // Back-to-back call/return mix.
        op(1'b1, CALL, 6'h08);
        op(1'b1, CALL, 6'h18);
        op(1'b1, RET, 6'h00);
        op(1'b1, CALL, 6'h28);
        op(1'b1, RET, 6'h00);
        op(1'b1, RET, 6'h00);
        op(1'b1, BRR, 6'd31);

        // Async reset mid-operation at PC=0x0A5 with a pending INC and a live stack entry.
        op(1'b1, JMP, 6'h3F);
        op(1'b1, BRR, 6'd31);
        op(1'b1, BRR, 6'd31);
        op(1'b1, BRR, 6'd31);
        op(1'b1, BRR, 6'd9);
        chk("pre_reset_pc", int'(o_PCcurr), 'h0A5);
        op(1'b1, CALL, 6'h25);
        i_PC   = 1'b1;
        i_PCop = INC;
        #2 reset = 1'b0;
        #1;
        chk("async_reset_pc", int'(o_PCcurr), 0);
        chk("async_reset_depth", int'(o_Depth), 0);
        @(negedge clk);
        i_PCop = RET;
        reset  = 1'b1;
        @(negedge clk);
        chk("post_reset_ret_pc", int'(o_PCcurr), 0);
`ifdef PC_SEQ_RET_STACK_EN
        chk("post_reset_unf", int'(o_Unf), 1);
`endif
        op(1'b1, INC, 6'h00);
        chk("post_reset_inc", int'(o_PCcurr), 1);
        op(1'b0, INC, 6'h00);

        chk_on = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pc_seq.md
PC_SEQ -- requirements
Module: pc_seq

Interface
REQ-001 Parameter PC_W, default 13, SHALL set program counter width in bits.
REQ-002 Parameter BR_W, default 6, SHALL set branch target / offset field width (BR_W <= PC_W).
REQ-003 Parameter DEPTH, default 4, SHALL set return-stack entry count (>= 1).
REQ-004 clk  input  1  SHALL be the sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 i_PC  input  1  SHALL be the advance enable; state changes only when 1.
REQ-007 i_PCop  input  3  SHALL select the next-PC operation.
REQ-008 i_Target  input  BR_W  SHALL carry the absolute target or signed relative offset.
REQ-009 o_PCcurr  output  PC_W  SHALL present the current PC, registered.
REQ-010 o_Depth  output  ceil(log2(DEPTH+1))  SHALL present the number of valid return-stack entries.
REQ-011 o_Ovf  output  1  SHALL pulse high one cycle on rejected CALL (stack full).
REQ-012 o_Unf  output  1  SHALL pulse high one cycle on rejected RET (stack empty).

Function
REQ-013 With i_PC=0, o_PCcurr, stack, and o_Depth SHALL hold; o_Ovf/o_Unf SHALL be 0 next cycle.
REQ-014 i_PCop=000 (INC) SHALL load PC+1 modulo 2^PC_W; all-ones SHALL wrap to 0.
REQ-015 i_PCop=001 (JMP) SHALL load i_Target zero-extended to PC_W.
REQ-016 i_PCop=010 (BRR) SHALL load PC + sign-extended i_Target, modulo 2^PC_W, wrapping in both directions.
REQ-017 i_PCop=011 (CALL), stack not full, SHALL push PC+1 (mod 2^PC_W), load zero-extended i_Target, and increment o_Depth, all in one cycle.
REQ-018 CALL with o_Depth=DEPTH SHALL leave PC, stack, and o_Depth unchanged and assert o_Ovf for exactly the next cycle.
REQ-019 i_PCop=100 (RET), stack not empty, SHALL load the top entry into PC and decrement o_Depth in one cycle.
REQ-020 RET with o_Depth=0 SHALL leave PC unchanged and assert o_Unf for exactly the next cycle.
REQ-021 i_PCop 101, 110, 111 (reserved) SHALL hold all state and raise no flag.
REQ-022 Latency: every operation SHALL be visible on o_PCcurr one clock after the enabled edge; no combinational path from inputs to outputs.
REQ-023 The stack SHALL be LIFO; entries above o_Depth SHALL be don't-care and unobservable.
REQ-024 Back-to-back CALL/RET on consecutive enabled cycles SHALL be supported without bubbles.

Reset
REQ-025 reset=0 SHALL immediately, independent of clk, set o_PCcurr=0, o_Depth=0, o_Ovf=0, o_Unf=0.
REQ-026 Reset asserted mid-operation SHALL discard any in-flight update; the first enabled edge after release SHALL act on PC=0 with an empty stack.
REQ-027 Stack storage contents SHALL NOT need reset.

Configuration
REQ-028 Macro PC_SEQ_RET_STACK_EN defined: return stack, CALL/RET, o_Ovf, o_Unf behave per REQ-017..REQ-020.
REQ-029 Macro undefined: no stack storage; CALL SHALL behave as JMP; RET SHALL behave as reserved (hold); o_Depth, o_Ovf, o_Unf SHALL be tied 0.

Verification
REQ-030 reset=0 mid-cycle with PC=0x0A5 -> o_PCcurr=0 before next clk edge; o_Depth=0.
REQ-031 PC=0x1FFF, INC -> o_PCcurr=0x0000; PC=0x0003, BRR i_Target=6'b111011 (-5) -> o_PCcurr=0x1FFE.
REQ-032 PC=0x0010, CALL 0x20 -> PC=0x0020, Depth=1; CALL 0x30 -> PC=0x0030, Depth=2; RET -> PC=0x0021; RET -> PC=0x0011, Depth=0.
REQ-033 Four CALLs fill stack (DEPTH=4); fifth CALL -> PC unchanged, o_Ovf=1 one cycle, Depth=4; RET at Depth=0 -> o_Unf=1 one cycle, PC unchanged.
REQ-034 i_PC=0 with i_PCop=JMP 0x3F for 5 cycles -> o_PCcurr constant; i_PCop=111 with i_PC=1 -> no change, no flags.
REQ-035 Build without PC_SEQ_RET_STACK_EN: CALL 0x15 -> PC=0x0015, o_Depth=0; RET -> PC unchanged, o_Unf=0.
